router_lookup_arb: RTL

- Shares the single combinational lookup port of the NoC routing table among NUM_REQ input-port requesters.
- Round-robin grant, one lookup in flight, registered table address, per-requester response buffer with valid/ready handshake.
- Sits between the router input ports and the routing table. A cfg_hold input freezes new grants while the APB side reprograms the table.

---
 rtl/router_lookup_arb.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/router_lookup_arb.sv
// Round-robin arbiter sharing one combinational routing-table lookup port among NUM_REQ requesters.
// Optional hit/miss statistics counters are compiled in when LOOKUP_STATS_EN is defined.
module router_lookup_arb #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int PORT_W  = 2,
    parameter int IDX_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [NUM_REQ*PORT_W-1:0] rsp_port,
    output logic [NUM_REQ-1:0]        rsp_hit,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    input  logic                      cfg_hold,
    output logic [ADDR_W-1:0]         lookup_addr,
    input  logic [PORT_W-1:0]         output_port,
    input  logic                      hit,
    output logic                      busy
`ifdef LOOKUP_STATS_EN
    ,
    input  logic                      stat_clr,
    output logic [15:0]               stat_hit_cnt,
    output logic [15:0]               stat_miss_cnt
`endif
);

    localparam int CW = IDX_W + 1;

    typedef enum logic {ST_IDLE, ST_LOOKUP} state_t;

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         lookup_addr_q, lookup_addr_d;
    logic [IDX_W-1:0]          gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ*PORT_W-1:0] rsp_port_q, rsp_port_d;
    logic [NUM_REQ-1:0]        rsp_hit_q, rsp_hit_d;

    logic [NUM_REQ-1:0]        elig;
    logic                      found;
    logic [IDX_W-1:0]          sel;
    logic [CW-1:0]             cand;
    logic                      grant;

    // A requester holding an unconsumed result is never eligible, so captures cannot overwrite.
    always_comb begin
        elig  = req_valid & ~rsp_valid_q;
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + CW'(k);
            if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
            if (!found && elig[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                sel   = cand[IDX_W-1:0];
            end
        end
    end

    assign grant = (state_q == ST_IDLE) && !cfg_hold && found;

    always_comb begin
        state_d       = state_q;
        lookup_addr_d = lookup_addr_q;
        gnt_idx_d     = gnt_idx_q;
        rr_ptr_d      = rr_ptr_q;
        rsp_port_d    = rsp_port_q;
        rsp_hit_d     = rsp_hit_q;
        rsp_valid_d   = rsp_valid_q & ~rsp_ready;
        req_ready     = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    req_ready[sel] = 1'b1;
                    lookup_addr_d  = req_addr[sel*ADDR_W +: ADDR_W];
                    gnt_idx_d      = sel;
                    rr_ptr_d       = (sel == IDX_W'(NUM_REQ-1)) ? '0 : sel + 1'b1;
                    state_d        = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                rsp_port_d[gnt_idx_q*PORT_W +: PORT_W] = output_port;
                rsp_hit_d[gnt_idx_q]   = hit;
                rsp_valid_d[gnt_idx_q] = 1'b1;
                state_d                = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            lookup_addr_q <= '0;
            gnt_idx_q     <= '0;
            rr_ptr_q      <= '0;
            rsp_valid_q   <= '0;
            rsp_port_q    <= '0;
            rsp_hit_q     <= '0;
        end else begin
            state_q       <= state_d;
            lookup_addr_q <= lookup_addr_d;
            gnt_idx_q     <= gnt_idx_d;
            rr_ptr_q      <= rr_ptr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_port_q    <= rsp_port_d;
            rsp_hit_q     <= rsp_hit_d;
        end
    end

    assign lookup_addr = lookup_addr_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_port    = rsp_port_q;
    assign rsp_hit     = rsp_hit_q;
    assign busy        = (state_q == ST_LOOKUP);

`ifdef LOOKUP_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    // Saturating counters; a clear in the capture cycle wins.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == ST_LOOKUP) begin
            if (hit) begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
            end
        end
        if (stat_clr) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign stat_hit_cnt  = hit_cnt_q;
    assign stat_miss_cnt = miss_cnt_q;
`endif

endmodule
